// File: rtl/bus_host_arbiter_2.sv
// Two-host to one-device strobe/ready bus arbiter, grant held for a whole transaction.
// Optional busy-cycle watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_host_arbiter_2 #(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] h0_addr,
  input  logic [31:0] h0_wdata,
  input  logic [3:0]  h0_wmask,
  input  logic        h0_wen,
  input  logic        h0_ren,
  output logic [31:0] h0_rdata,
  output logic        h0_ready,
  input  logic [31:0] h1_addr,
  input  logic [31:0] h1_wdata,
  input  logic [3:0]  h1_wmask,
  input  logic        h1_wen,
  input  logic        h1_ren,
  output logic [31:0] h1_rdata,
  output logic        h1_ready,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_wmask,
  output logic        dev_wen,
  output logic        dev_ren,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        arb_timeout_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [0:0] state;
  logic       owner;
  logic       rr_ptr;
  logic       req0;
  logic       req1;
  logic       pick;
  logic       in_busy;
  logic       to_hit;
  logic       done;
  logic       rdy;
  logic [31:0] rd;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_wmask;
  logic        own_wen;
  logic        own_ren;

  assign req0 = h0_wen | h0_ren;
  assign req1 = h1_wen | h1_ren;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      req0 && req1: pick = (FIXED_PRIORITY != 0) ? 1'b0 : rr_ptr;
      req1 && !req0: pick = 1'b1;
      default: pick = 1'b0;
    endcase
  end

  assign own_addr  = owner ? h1_addr  : h0_addr;
  assign own_wdata = owner ? h1_wdata : h0_wdata;
  assign own_wmask = owner ? h1_wmask : h0_wmask;
  assign own_wen   = owner ? h1_wen   : h0_wen;
  assign own_ren   = owner ? h1_ren   : h0_ren;

  // Outputs are forced idle while rst is high so a late dev_ready is dropped.
  assign in_busy = (state == BUSY) && !rst;

  assign dev_addr  = in_busy ? own_addr  : 32'h0;
  assign dev_wdata = in_busy ? own_wdata : 32'h0;
  assign dev_wmask = in_busy ? own_wmask : 4'h0;
  assign dev_wen   = in_busy & own_wen & ~to_hit;
  assign dev_ren   = in_busy & own_ren & ~own_wen & ~to_hit;

  assign rd  = to_hit ? 32'hDEAD_BEEF : dev_rdata;
  assign rdy = in_busy & (dev_ready | to_hit);

  assign h0_ready = rdy & ~owner;
  assign h1_ready = rdy & owner;
  assign h0_rdata = (in_busy & ~owner) ? rd : 32'h0;
  assign h1_rdata = (in_busy & owner)  ? rd : 32'h0;

  assign grant = in_busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy  = in_busy;

  // Completion, watchdog expiry, or the owner abandoning its strobes.
  assign done = dev_ready | to_hit | ~(own_wen | own_ren);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state <= BUSY;
            owner <= pick;
          end
        end
        default: begin
          if (done) begin
            state  <= IDLE;
            rr_ptr <= ~owner;
          end
        end
      endcase
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt;
  logic          to_err;

  assign to_hit = (state == BUSY) && !dev_ready && (to_cnt == TO_LAST);
  assign arb_timeout_err = to_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (state == IDLE) begin
        to_cnt <= '0;
      end else if (!dev_ready) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (to_hit) begin
        to_err <= 1'b1;
      end
    end
  end
`else
  assign to_hit = 1'b0;
  assign arb_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_host_arbiter_2.sv
// Scoreboard bench for bus_host_arbiter_2: round-robin and fixed-priority instances
// share host stimulus; each has its own latency-programmable device model.
module tb_bus_host_arbiter_2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] h0_addr = 0, h0_wdata = 0, h1_addr = 0, h1_wdata = 0;
  logic [3:0]  h0_wmask = 0, h1_wmask = 0;
  logic        h0_wen = 0, h0_ren = 0, h1_wen = 0, h1_ren = 0;
  logic [31:0] rdata_val = 0;
  logic [7:0]  lat = 0;
  logic        dev_dead = 0;
  logic        force_rdy = 0;

  logic [31:0] rr_h0_rdata, rr_h1_rdata, rr_dev_addr, rr_dev_wdata;
  logic        rr_h0_ready, rr_h1_ready, rr_dev_wen, rr_dev_ren, rr_dev_ready;
  logic [3:0]  rr_dev_wmask;
  logic [1:0]  rr_grant;
  logic        rr_busy, rr_err;

  logic [31:0] fp_h0_rdata, fp_h1_rdata, fp_dev_addr, fp_dev_wdata;
  logic        fp_h0_ready, fp_h1_ready, fp_dev_wen, fp_dev_ren, fp_dev_ready;
  logic [3:0]  fp_dev_wmask;
  logic [1:0]  fp_grant;
  logic        fp_busy, fp_err;

  logic [7:0] dcnt_rr = 0;
  logic [7:0] dcnt_fp = 0;

  assign rr_dev_ready = force_rdy |
    (!dev_dead && (rr_dev_wen | rr_dev_ren) && dcnt_rr == lat);
  assign fp_dev_ready = !dev_dead && (fp_dev_wen | fp_dev_ren) && dcnt_fp == lat;

  always @(posedge clk) begin
    if (!(rr_dev_wen | rr_dev_ren) || rr_dev_ready) dcnt_rr <= 0;
    else dcnt_rr <= dcnt_rr + 1;
    if (!(fp_dev_wen | fp_dev_ren) || fp_dev_ready) dcnt_fp <= 0;
    else dcnt_fp <= dcnt_fp + 1;
  end

  bus_host_arbiter_2 #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) u_rr (
    .clk(clk), .rst(rst),
    .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_wmask(h0_wmask),
    .h0_wen(h0_wen), .h0_ren(h0_ren),
    .h0_rdata(rr_h0_rdata), .h0_ready(rr_h0_ready),
    .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_wmask(h1_wmask),
    .h1_wen(h1_wen), .h1_ren(h1_ren),
    .h1_rdata(rr_h1_rdata), .h1_ready(rr_h1_ready),
    .dev_addr(rr_dev_addr), .dev_wdata(rr_dev_wdata), .dev_wmask(rr_dev_wmask),
    .dev_wen(rr_dev_wen), .dev_ren(rr_dev_ren),
    .dev_rdata(rdata_val), .dev_ready(rr_dev_ready),
    .grant(rr_grant), .busy(rr_busy), .arb_timeout_err(rr_err)
  );

  bus_host_arbiter_2 #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(8)) u_fp (
    .clk(clk), .rst(rst),
    .h0_addr(h0_addr), .h0_wdata(h0_wdata), .h0_wmask(h0_wmask),
    .h0_wen(h0_wen), .h0_ren(h0_ren),
    .h0_rdata(fp_h0_rdata), .h0_ready(fp_h0_ready),
    .h1_addr(h1_addr), .h1_wdata(h1_wdata), .h1_wmask(h1_wmask),
    .h1_wen(h1_wen), .h1_ren(h1_ren),
    .h1_rdata(fp_h1_rdata), .h1_ready(fp_h1_ready),
    .dev_addr(fp_dev_addr), .dev_wdata(fp_dev_wdata), .dev_wmask(fp_dev_wmask),
    .dev_wen(fp_dev_wen), .dev_ren(fp_dev_ren),
    .dev_rdata(rdata_val), .dev_ready(fp_dev_ready),
    .grant(fp_grant), .busy(fp_busy), .arb_timeout_err(fp_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        host;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
  } sb_t;

  sb_t sbq[$];
  logic mon_en = 0;

  always @(negedge clk) begin
    sb_t e;
    if (mon_en && !rst) begin
      if (rr_busy && sbq.size() != 0)
        chk("grant", rr_grant, sbq[0].host ? 2'b10 : 2'b01);
      if (rr_h0_ready | rr_h1_ready) begin
        chk("sb_pending", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("rdy_host", rr_h1_ready, e.host);
          chk("both_rdy", rr_h0_ready & rr_h1_ready, 0);
          chk("dev_addr", rr_dev_addr, e.addr);
          chk("dev_wmask", rr_dev_wmask, e.wmask);
          chk("dev_wen", rr_dev_wen, e.wen);
          chk("dev_ren", rr_dev_ren, e.ren);
          chk("rdata", e.host ? rr_h1_rdata : rr_h0_rdata, e.rdata);
          chk("other_rdata", e.host ? rr_h0_rdata : rr_h1_rdata, 0);
        end
      end
    end
  end

  logic trace_en = 0;
  logic rr_prev = 0, fp_prev = 0;
  logic [1:0] rr_tr[$];
  logic [1:0] fp_tr[$];

  always @(negedge clk) begin
    if (trace_en) begin
      if (rr_busy && !rr_prev) rr_tr.push_back(rr_grant);
      if (fp_busy && !fp_prev) fp_tr.push_back(fp_grant);
    end
    rr_prev <= rr_busy;
    fp_prev <= fp_busy;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic txn(input bit h, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input logic we, input logic re,
                     output int cyc);
    bit got;
    if (h) begin
      h1_addr = a; h1_wdata = wd; h1_wmask = m; h1_wen = we; h1_ren = re;
    end else begin
      h0_addr = a; h0_wdata = wd; h0_wmask = m; h0_wen = we; h0_ren = re;
    end
    cyc = 0;
    got = 0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      got = h ? rr_h1_ready : rr_h0_ready;
    end
    chk("txn_bound", got, 1);
    @(posedge clk); #1;
    if (h) begin h1_wen = 0; h1_ren = 0; end
    else begin h0_wen = 0; h0_ren = 0; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", rr_grant, 0);
    chk("rst_busy", rr_busy, 0);
    chk("rst_dev_str", {rr_dev_wen, rr_dev_ren}, 0);
    chk("rst_dev_addr", rr_dev_addr, 0);
    chk("rst_ready", {rr_h0_ready, rr_h1_ready}, 0);
    chk("rst_rdata", rr_h1_rdata, 0);
    chk("rst_err", rr_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1;

    lat = 3; rdata_val = 32'h1234_5678;
    sbq.push_back('{1'b0, 32'h40, 4'h0, 1'b0, 1'b1, 32'h1234_5678});
    fork
      txn(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, c0);
      begin
        @(negedge clk); chk("t1_ren_n", rr_dev_ren, 0);
        @(negedge clk); chk("t1_ren_n1", rr_dev_ren, 1);
      end
    join
    chk("t1_lat", c0, 5);
    repeat (2) @(posedge clk);

    do_reset();
    lat = 1; rdata_val = 32'hCAFE_0001;
    sbq.push_back('{1'b0, 32'h100, 4'hF, 1'b1, 1'b0, 32'hCAFE_0001});
    sbq.push_back('{1'b1, 32'h2000_0200, 4'b0011, 1'b1, 1'b0, 32'hCAFE_0001});
    fork
      txn(1'b0, 32'h100, 32'h1111, 4'hF, 1'b1, 1'b0, c0);
      txn(1'b1, 32'h2000_0200, 32'h2222, 4'b0011, 1'b1, 1'b0, c1);
    join
    chk("t2_h0_lat", c0, 3);
    chk("t2_h1_lat", c1, 6);

    lat = 2; rdata_val = 32'h0BAD_F00D;
    sbq.push_back('{1'b1, 32'h300, 4'hF, 1'b1, 1'b0, 32'h0BAD_F00D});
    txn(1'b1, 32'h300, 32'h55, 4'hF, 1'b1, 1'b1, c1);
    chk("t3_lat", c1, 4);

    lat = 10;
    h1_addr = 32'h400; h1_ren = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; force_rdy = 1; h1_ren = 0;
    @(negedge clk);
    chk("t5_rdy_in_rst", {rr_h0_ready, rr_h1_ready}, 0);
    chk("t5_str_in_rst", {rr_dev_wen, rr_dev_ren}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_grant", rr_grant, 0);
    chk("t5_busy", rr_busy, 0);
    chk("t5_ready", {rr_h0_ready, rr_h1_ready}, 0);
    @(posedge clk); #1 rst = 1'b0; force_rdy = 0;
    @(negedge clk);
    chk("t5_idle", rr_busy, 0);
    chk("t5_sb_empty", sbq.size(), 0);

    do_reset();
    mon_en = 0; lat = 0; trace_en = 1;
    h0_addr = 32'h800; h1_addr = 32'h900;
    h0_ren = 1; h1_ren = 1;
    repeat (16) @(posedge clk);
    #1 h0_ren = 0; h1_ren = 0; trace_en = 0;
    chk("rr_trace_len", rr_tr.size() >= 4, 1);
    chk("fp_trace_len", fp_tr.size() >= 4, 1);
    for (int i = 0; i < 4 && i < rr_tr.size(); i++)
      chk("rr_seq", rr_tr[i], (i % 2) ? 2'b10 : 2'b01);
    for (int i = 0; i < fp_tr.size(); i++)
      chk("fp_seq", fp_tr[i], 2'b01);
    repeat (2) @(posedge clk);

`ifdef BUS_ARB_TIMEOUT_EN
    do_reset();
    mon_en = 1; dev_dead = 1;
    sbq.push_back('{1'b0, 32'h500, 4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF});
    txn(1'b0, 32'h500, 32'h0, 4'h0, 1'b0, 1'b1, c0);
    chk("to_lat", c0, 9);
    @(negedge clk);
    chk("to_err_set", rr_err, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("to_err_sticky", rr_err, 1);
    dev_dead = 0;
    do_reset();
    @(negedge clk);
    chk("to_err_clr", rr_err, 0);
`else
    chk("no_to_err", rr_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
